mdr_request_arbiter: RTL and testbench

- Shares one MDR datapath and its control unit between N_REQ requesters.
- Accepts operand/opcode requests over valid/ready and picks one requester by round-robin.
- Drives the MDR start/load strobe sequence (X, Y, opcode), waits for the MDR ready or error flag under a timeout, then returns a tagged response over valid/ready.
- Only one operation is in flight at a time.

---
 rtl/mdr_request_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mdr_request_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_request_arbiter.sv
// mdr_request_arbiter
//   Shares a single MDR datapath between N_REQ requesters. Requests are
//   accepted over valid/ready and arbitrated round-robin. The winner's
//   operands are then pushed through the MDR strobe sequence
//   (start, X, Y, opcode). The arbiter waits for the MDR ready or error
//   flag, bounded by a timeout, and answers with a tagged response.
//   Only one operation is in flight at a time.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester handshake (ready is one-hot or zero)
//   req_x, req_y, req_op     packed operands/opcodes, slice i for requester i
//   rsp_valid/rsp_ready      response handshake
//   rsp_id                   index of the requester being answered
//   rsp_result               MDR result (0 on timeout)
//   rsp_error, rsp_timeout   completion status
//   mdr_start, mdr_load      strobes to the MDR control unit
//   mdr_data                 operand/opcode bus to the MDR
//   mdr_result               result returned by the MDR
//   mdr_ready, mdr_error     MDR completion flags
//   busy                     high whenever the arbiter is not idle
module mdr_request_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 16,
  parameter int OP_W    = 2,
  parameter int TIMEOUT = 255,
  localparam int ID_W   = $clog2(N_REQ),
  localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_x,
  input  logic [N_REQ*DATA_W-1:0] req_y,
  input  logic [N_REQ*OP_W-1:0]   req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_result,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic                    mdr_start,
  output logic                    mdr_load,
  output logic [DATA_W-1:0]       mdr_data,
  input  logic [DATA_W-1:0]       mdr_result,
  input  logic                    mdr_ready,
  input  logic                    mdr_error,
  output logic                    busy
);

  typedef enum logic [3:0] {
    IDLE, START, GAP0, LDX, GAP1, LDY, GAP2, LDOP, WAIT, RESP
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   cap_id;
  logic [DATA_W-1:0] cap_x;
  logic [DATA_W-1:0] cap_y;
  logic [OP_W-1:0]   cap_op;
  logic [CNT_W-1:0]  wait_cnt;

  logic              grant_any;
  logic [ID_W-1:0]   grant_idx;
  logic [N_REQ-1:0]  grant_onehot;

  // Round-robin search starting at ptr and wrapping around.
  always_comb begin
    int idx;
    idx          = 0;
    grant_any    = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      grant_onehot[j] = grant_any && (ID_W'(j) == grant_idx);
    end
  end

  // The accept is combinational so the requester sees it in the grant cycle.
  // It is masked during reset so that no grant is reported while the
  // arbiter is being cleared.
  assign req_ready = (state == IDLE && !rst) ? grant_onehot : '0;

  // The strobes and response fields are registered. Each one is set on the
  // transition into the state that owns it, so it is valid for exactly
  // that state's cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cap_id      <= '0;
      cap_x       <= '0;
      cap_y       <= '0;
      cap_op      <= '0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_result  <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      mdr_start   <= 1'b0;
      mdr_load    <= 1'b0;
      mdr_data    <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            cap_id    <= grant_idx;
            cap_x     <= req_x[int'(grant_idx)*DATA_W +: DATA_W];
            cap_y     <= req_y[int'(grant_idx)*DATA_W +: DATA_W];
            cap_op    <= req_op[int'(grant_idx)*OP_W +: OP_W];
            ptr       <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + ID_W'(1);
            mdr_start <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          mdr_start <= 1'b0;
          state     <= GAP0;
        end
        GAP0: begin
          mdr_load <= 1'b1;
          mdr_data <= cap_x;
          state    <= LDX;
        end
        LDX: begin
          mdr_load <= 1'b0;
          mdr_data <= '0;
          state    <= GAP1;
        end
        GAP1: begin
          mdr_load <= 1'b1;
          mdr_data <= cap_y;
          state    <= LDY;
        end
        LDY: begin
          mdr_load <= 1'b0;
          mdr_data <= '0;
          state    <= GAP2;
        end
        GAP2: begin
          mdr_load <= 1'b1;
          mdr_data <= DATA_W'(cap_op);
          state    <= LDOP;
        end
        LDOP: begin
          mdr_load <= 1'b0;
          mdr_data <= '0;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // Error takes precedence over ready. The timeout fires only if
          // neither flag shows up in the last allowed cycle.
          if (mdr_error || mdr_ready) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= cap_id;
            rsp_result  <= mdr_result;
            rsp_error   <= mdr_error;
            rsp_timeout <= 1'b0;
            state       <= RESP;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= cap_id;
            rsp_result  <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_request_arbiter.sv
// tb_mdr_request_arbiter
//   Directed bench for mdr_request_arbiter with N_REQ=4, DATA_W=16, OP_W=2
//   and TIMEOUT=4. Inputs are driven on the falling edge. Outputs are
//   sampled on the falling edge, or 1 ns later for combinational accepts.
module tb_mdr_request_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*DW-1:0] req_x;
  logic [N*DW-1:0] req_y;
  logic [N*OW-1:0] req_op;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [DW-1:0] rsp_result;
  logic          rsp_error;
  logic          rsp_timeout;
  logic          mdr_start;
  logic          mdr_load;
  logic [DW-1:0] mdr_data;
  logic [DW-1:0] mdr_result;
  logic          mdr_ready;
  logic          mdr_error;
  logic          busy;

  int total = 0;
  int bad   = 0;

  mdr_request_arbiter #(
    .N_REQ(N), .DATA_W(DW), .OP_W(OW), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .mdr_start(mdr_start), .mdr_load(mdr_load), .mdr_data(mdr_data),
    .mdr_result(mdr_result), .mdr_ready(mdr_ready), .mdr_error(mdr_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Holds v on req_valid until a grant shows up, for at most 8 cycles.
  // On return, the current cycle is the grant cycle.
  task automatic issue(input logic [N-1:0] v, output logic [N-1:0] seen, output bit ok);
    ok   = 1'b0;
    seen = '0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      req_valid = v;
      #1;
      if (req_ready !== '0) begin
        seen = req_ready;
        ok   = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_op = '0;
    rsp_ready = 1'b0; mdr_result = '0; mdr_ready = 1'b0; mdr_error = 1'b0;
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    total++; if ({mdr_start, mdr_load, mdr_data} !== '0) begin bad++; $display("[TB] FAIL reset_mdr got %b/%b/%h want 0", mdr_start, mdr_load, mdr_data); end
    total++; if ({rsp_id, rsp_result, rsp_error, rsp_timeout} !== '0) begin bad++; $display("[TB] FAIL reset_rsp got %h/%h/%b/%b want 0", rsp_id, rsp_result, rsp_error, rsp_timeout); end
    total++; if (req_ready !== '0) begin bad++; $display("[TB] FAIL reset_req_ready got %b want 0", req_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [N-1:0] seen; bit ok;
    req_x[0*DW +: DW] = 16'h0005;
    req_y[0*DW +: DW] = 16'h0003;
    req_op[0*OW +: OW] = 2'd2;
    rsp_ready = 1'b1;
    issue(4'b0001, seen, ok);
    total++; if (!ok || seen !== 4'b0001) begin bad++; $display("[TB] FAIL single_grant got %b want 0001", seen); end
    tick(); req_valid = '0;                                         // T+1
    total++; if ({mdr_start, mdr_load} !== 2'b10 || busy !== 1'b1) begin bad++; $display("[TB] FAIL single_start got s=%b l=%b busy=%b want 1/0/1", mdr_start, mdr_load, busy); end
    tick();                                                         // T+2
    total++; if ({mdr_start, mdr_load} !== 2'b00) begin bad++; $display("[TB] FAIL single_gap0 got s=%b l=%b want 0/0", mdr_start, mdr_load); end
    tick();                                                         // T+3
    total++; if (mdr_load !== 1'b1 || mdr_data !== 16'h0005) begin bad++; $display("[TB] FAIL single_ldx got l=%b d=%h want 1/0005", mdr_load, mdr_data); end
    tick();                                                         // T+4
    total++; if (mdr_load !== 1'b0 || mdr_data !== 16'h0000) begin bad++; $display("[TB] FAIL single_gap1 got l=%b d=%h want 0/0000", mdr_load, mdr_data); end
    tick();                                                         // T+5
    total++; if (mdr_load !== 1'b1 || mdr_data !== 16'h0003) begin bad++; $display("[TB] FAIL single_ldy got l=%b d=%h want 1/0003", mdr_load, mdr_data); end
    tick();                                                         // T+6
    tick();                                                         // T+7
    total++; if (mdr_load !== 1'b1 || mdr_data !== 16'h0002) begin bad++; $display("[TB] FAIL single_ldop got l=%b d=%h want 1/0002", mdr_load, mdr_data); end
    tick();                                                         // T+8
    total++; if (mdr_load !== 1'b0 || mdr_data !== 16'h0000) begin bad++; $display("[TB] FAIL single_wait_bus got l=%b d=%h want 0/0000", mdr_load, mdr_data); end
    tick();                                                         // T+9
    tick(); mdr_ready = 1'b1; mdr_result = 16'h000F;                // T+10
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_early_rsp got %b want 0", rsp_valid); end
    tick(); mdr_ready = 1'b0; mdr_result = '0;                      // T+11
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 16'h000F || rsp_error !== 1'b0 || rsp_timeout !== 1'b0)
      begin bad++; $display("[TB] FAIL single_rsp got v=%b id=%0d r=%h e=%b t=%b want 1/0/000f/0/0", rsp_valid, rsp_id, rsp_result, rsp_error, rsp_timeout); end
    tick();                                                         // T+12
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL single_done got v=%b busy=%b want 0/0", rsp_valid, busy); end
  endtask

  task automatic test_round_robin();
    int grants[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int last_grant = -1;
    bit prev_hi = 1'b0;
    bit done = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 45; c++) begin
      tick();
      req_valid = 4'b1111; mdr_ready = 1'b1; rsp_ready = 1'b1;
      #1;
      if (req_ready !== '0) begin
        total++;
        if (!$onehot(req_ready) || prev_hi) begin bad++; $display("[TB] FAIL rr_pulse got %b at cycle %0d want single one-hot", req_ready, c); end
        for (int i = 0; i < N; i++) if (req_ready[i]) last_grant = i;
        grants.push_back(last_grant);
        prev_hi = 1'b1;
      end else begin
        prev_hi = 1'b0;
      end
      if (rsp_valid === 1'b1) begin
        total++;
        if (int'(rsp_id) != last_grant) begin bad++; $display("[TB] FAIL rr_rsp_id got %0d want %0d", rsp_id, last_grant); end
      end
    end
    total++;
    if (grants.size() != 5) begin bad++; $display("[TB] FAIL rr_count got %0d want 5", grants.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (grants[i] != exp_order[i]) begin bad++; $display("[TB] FAIL rr_order[%0d] got %0d want %0d", i, grants[i], exp_order[i]); end
      end
    end
    tick(); req_valid = '0;
    for (int c = 0; c < 30 && !done; c++) begin tick(); if (busy === 1'b0) done = 1'b1; end
    total++; if (!done) begin bad++; $display("[TB] FAIL rr_drain got busy=%b want 0", busy); end
    mdr_ready = 1'b0;
  endtask

  task automatic test_error_precedence();
    logic [N-1:0] seen; bit ok;
    mdr_ready = 1'b0; mdr_error = 1'b0; rsp_ready = 1'b1;
    issue(4'b0100, seen, ok);
    total++; if (!ok || seen !== 4'b0100) begin bad++; $display("[TB] FAIL err_grant got %b want 0100", seen); end
    tick(); req_valid = '0;
    repeat (6) tick();                                              // T+7
    tick(); mdr_ready = 1'b1; mdr_error = 1'b1; mdr_result = 16'h1234; // T+8
    tick(); mdr_ready = 1'b0; mdr_error = 1'b0; mdr_result = '0;    // T+9
    total++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_timeout !== 1'b0 || rsp_result !== 16'h1234 || rsp_id !== 2'd2)
      begin bad++; $display("[TB] FAIL err_rsp got v=%b e=%b t=%b r=%h id=%0d want 1/1/0/1234/2", rsp_valid, rsp_error, rsp_timeout, rsp_result, rsp_id); end
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL err_consume got %b want 0", rsp_valid); end
  endtask

  task automatic test_timeout();
    logic [N-1:0] seen; bit ok;
    mdr_result = 16'hBEEF; rsp_ready = 1'b1;
    issue(4'b1000, seen, ok);
    total++; if (!ok || seen !== 4'b1000) begin bad++; $display("[TB] FAIL to_grant got %b want 1000", seen); end
    tick(); req_valid = '0;
    repeat (10) tick();                                             // T+11, fourth WAIT cycle
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL to_early got v=%b busy=%b want 0/1", rsp_valid, busy); end
    tick();                                                         // T+12
    total++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_error !== 1'b0 || rsp_result !== 16'h0000 || rsp_id !== 2'd3)
      begin bad++; $display("[TB] FAIL to_rsp got v=%b t=%b e=%b r=%h id=%0d want 1/1/0/0000/3", rsp_valid, rsp_timeout, rsp_error, rsp_result, rsp_id); end
    tick(); mdr_result = '0;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] seen; bit ok; bit done = 1'b0;
    rsp_ready = 1'b0;
    issue(4'b0010, seen, ok);
    total++; if (!ok || seen !== 4'b0010) begin bad++; $display("[TB] FAIL bp_grant got %b want 0010", seen); end
    repeat (7) tick();                                              // T+7
    tick(); mdr_ready = 1'b1; mdr_result = 16'h0AAA;                // T+8
    for (int i = 0; i < 6; i++) begin                               // T+9 .. T+14
      tick();
      mdr_ready = 1'b0; mdr_result = '0;
      if (i == 5) rsp_ready = 1'b1;
      #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 16'h0AAA || rsp_error !== 1'b0 || rsp_timeout !== 1'b0 || req_ready !== '0)
        begin bad++; $display("[TB] FAIL bp_hold[%0d] got v=%b id=%0d r=%h e=%b t=%b rdy=%b want 1/1/0aaa/0/0/0000", i, rsp_valid, rsp_id, rsp_result, rsp_error, rsp_timeout, req_ready); end
    end
    tick(); #1;                                                     // T+15
    total++; if (req_ready !== 4'b0010 || rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_regrant got rdy=%b v=%b want 0010/0", req_ready, rsp_valid); end
    tick(); req_valid = '0; mdr_ready = 1'b1;
    for (int c = 0; c < 30 && !done; c++) begin tick(); if (busy === 1'b0) done = 1'b1; end
    total++; if (!done) begin bad++; $display("[TB] FAIL bp_drain got busy=%b want 0", busy); end
    mdr_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [N-1:0] seen; bit ok; bit spurious = 1'b0; bit got = 1'b0;
    req_y[2*DW +: DW] = 16'h0777; rsp_ready = 1'b1;
    issue(4'b0100, seen, ok);
    total++; if (!ok || seen !== 4'b0100) begin bad++; $display("[TB] FAIL rmo_grant got %b want 0100", seen); end
    tick(); req_valid = '0;
    repeat (4) tick();                                              // T+5, LDY
    total++; if (mdr_load !== 1'b1 || mdr_data !== 16'h0777) begin bad++; $display("[TB] FAIL rmo_ldy got l=%b d=%h want 1/0777", mdr_load, mdr_data); end
    rst = 1'b1;
    tick(); rst = 1'b0; #1;                                         // T+6
    total++; if ({busy, mdr_start, mdr_load, mdr_data, rsp_valid, rsp_id, rsp_result, rsp_error, rsp_timeout, req_ready} !== '0)
      begin bad++; $display("[TB] FAIL rmo_clear got busy=%b s=%b l=%b d=%h v=%b id=%0d r=%h e=%b t=%b rdy=%b want all 0", busy, mdr_start, mdr_load, mdr_data, rsp_valid, rsp_id, rsp_result, rsp_error, rsp_timeout, req_ready); end
    for (int c = 0; c < 12; c++) begin tick(); if (rsp_valid !== 1'b0 || busy !== 1'b0) spurious = 1'b1; end
    total++; if (spurious) begin bad++; $display("[TB] FAIL rmo_no_rsp got a response or busy after reset want none"); end
    // With the pointer back at 0, requesters 2 and 3 both valid must pick 2.
    mdr_ready = 1'b1;
    issue(4'b1100, seen, ok);
    total++; if (!ok || seen !== 4'b0100) begin bad++; $display("[TB] FAIL rmo_regrant got %b want 0100", seen); end
    for (int c = 0; c < 20 && !got; c++) begin
      tick(); req_valid = '0;
      if (rsp_valid === 1'b1) got = 1'b1;
    end
    total++; if (!got || rsp_id !== 2'd2 || rsp_timeout !== 1'b0) begin bad++; $display("[TB] FAIL rmo_rsp got v=%b id=%0d t=%b want 1/2/0", got, rsp_id, rsp_timeout); end
    tick(); mdr_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_error_precedence();
    test_timeout();
    test_backpressure();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
